mult_acc_stage: RTL and testbench
=================================

Name: mult_acc_stage

Overview:
- Downstream stage of the registered signed multiplier. Consumes its product stream and accumulates a programmable number of signed products per frame.
- Each frame produces one saturated dot-product result with a valid/ready output handshake.
- Sits between the multiplier's sum register and the result bus of the FASM datapath.

Parameters:
PW, 16, product width (width1+width2 of the feeding multiplier), signed two's complement
AW, 24, accumulator/result width; legal only if AW >= PW
CW, 8, frame-length counter width

Ports:
sys_clk  input  1  clock, rising edge
sys_rst_n  input  1  reset, asynchronous, active-low
en  input  1  stage enable; low = synchronous clear to IDLE
frame_len  input  CW  products per frame; sampled on first accept of a frame; 0 treated as 1
prod_valid  input  1  product present on prod_data
prod_data  input  PW  signed product from multiplier
prod_ready  output  1  stage accepts product this cycle
acc_valid  output  1  result frame available
acc_data  output  AW  signed accumulated result
acc_sat  output  1  result saturated at least once during this frame
acc_ready  input  1  downstream consumes result

Behaviour:
- Reset (sys_rst_n low, async): state=IDLE, acc_data=0, acc_valid=0, acc_sat=0, remaining=0. prod_ready=0 while reset is asserted.
- en low while sys_rst_n is high: on the next clock, same values as reset. Any in-flight frame is discarded. prod_ready=0 while en is low.
- Accept: a product is accepted when prod_valid && prod_ready on the rising edge. Result handoff occurs when acc_valid && acc_ready.
- prod_ready is combinational from state only: 1 in IDLE and ACC, 0 in DONE.
- No path from prod_valid to prod_ready, and no path from acc_ready to prod_ready.
- Sign extension: ext(p) = prod_data sign-extended to AW bits.
- Saturating add: sat_add(a,p) is computed at AW+1 bits.
  - If the result exceeds 2^(AW-1)-1, clamp to 2^(AW-1)-1.
  - If the result is below -2^(AW-1), clamp to -2^(AW-1).
  - Either clamp sets acc_sat=1, which is sticky until the next frame start.
- IDLE:
  - On accept: acc_data=ext(p), acc_sat=0, remaining=max(frame_len,1)-1.
  - If remaining==0, go to DONE; else go to ACC.
  - Without an accept, hold all registers.
- ACC:
  - On accept: acc_data=sat_add(acc_data,p), remaining=remaining-1.
  - When the accepted product is the last one (remaining==1 before decrement), go to DONE.
  - prod_valid low = stall; hold all registers.
- DONE:
  - acc_valid=1; acc_data and acc_sat are stable, and prod_ready=0.
  - On acc_ready, go to IDLE next cycle with acc_valid=0; acc_data keeps its last value until the next frame start.
- Latency: acc_valid rises on the clock edge that accepts the last product of the frame, so it is visible 1 cycle after that accept.
- Throughput: one product per cycle within a frame, plus 1 bubble cycle per frame (the DONE->IDLE handoff cycle does not accept).
- frame_len is ignored outside the IDLE accept cycle; changing it mid-frame has no effect.
- Boundaries:
  - frame_len=0 behaves as 1.
  - frame_len=2^CW-1 accumulates 255 products (CW=8).
  - Once saturated, the accumulator keeps adding from the clamped value; later opposite-sign products pull it back. acc_sat stays 1.
  - acc_ready held high before DONE has no effect.
  - acc_ready low in DONE holds the result indefinitely.
- All outputs are registered except prod_ready (state decode).

Test Plan:
- Reset mid-frame: frame_len=4, accept 2 products (100,200), assert sys_rst_n low for 1 cycle -> acc_valid=0, acc_data=0, prod_ready=0 during reset. Next frame with frame_len=1 and product 7 -> acc_data=7.
- Basic dot product: frame_len=3, products +300, -1000, +50 back-to-back, acc_ready=1 -> acc_valid high exactly 1 cycle after 3rd accept, acc_data=-650, acc_sat=0, one bubble before next accept.
- Saturation: AW=17, PW=16, frame_len=3, products 32767, 32767, 32767 -> acc_data=65535 (clamped), acc_sat=1. Negative case -32768 x3 -> acc_data=-65536, acc_sat=1.
- Backpressure and stalls: frame_len=2, prod_valid gaps of 3 cycles between products 5 and 9, acc_ready low 4 cycles -> prod_ready=0 and acc_data=14 stable throughout DONE; handoff on the first acc_ready cycle.
- frame_len=0 and mid-frame change: frame_len=0 with product -12 -> single-product result -12. frame_len=5 changed to 2 after the first accept -> still 5 products accumulated.
- en low in ACC: after 2 of 4 products, en=0 for 1 cycle -> state IDLE, acc_data=0, acc_valid=0. Subsequent frame accumulates from zero correctly.

Source files
------------

// File: rtl/mult_acc_stage_if.sv
// -----------------------------------------------------------------------------
// mult_acc_stage_if
//
// Bundles every signal between the product-accumulate stage and its
// environment, except for clock and reset, which stay plain ports.
//
//   en          stage enable; low clears the stage on the next clock
//   frame_len   products per frame, sampled on the first product of a frame
//   prod_valid  product present on prod_data
//   prod_data   signed product from the feeding multiplier (PW bits)
//   prod_ready  stage accepts a product this cycle
//   acc_valid   accumulated frame result available
//   acc_data    signed, saturated frame result (AW bits)
//   acc_sat     the result clamped at least once during the frame
//   acc_ready   downstream consumes the result
//
// Modports:
//   master  environment side: drives control, products and acc_ready
//   slave   stage side: consumes products, drives the result stream
// -----------------------------------------------------------------------------
interface mult_acc_stage_if #(
    parameter int PW = 16,
    parameter int AW = 24,
    parameter int CW = 8
) ();

    logic                 en;
    logic [CW-1:0]        frame_len;
    logic                 prod_valid;
    logic signed [PW-1:0] prod_data;
    logic                 prod_ready;
    logic                 acc_valid;
    logic signed [AW-1:0] acc_data;
    logic                 acc_sat;
    logic                 acc_ready;

    modport master (
        output en,
        output frame_len,
        output prod_valid,
        output prod_data,
        output acc_ready,
        input  prod_ready,
        input  acc_valid,
        input  acc_data,
        input  acc_sat
    );

    modport slave (
        input  en,
        input  frame_len,
        input  prod_valid,
        input  prod_data,
        input  acc_ready,
        output prod_ready,
        output acc_valid,
        output acc_data,
        output acc_sat
    );

endinterface : mult_acc_stage_if

// File: rtl/mult_acc_stage.sv
// -----------------------------------------------------------------------------
// mult_acc_stage
//
// Downstream stage of the registered signed multiplier. Accepts a stream of
// signed PW-bit products, accumulates a programmable number of them per frame
// into a saturating AW-bit accumulator, and presents one result per frame on
// a valid/ready handshake.
//
// Ports:
//   sys_clk    clock, rising edge
//   sys_rst_n  asynchronous, active-low reset
//   bus        mult_acc_stage_if.slave (enable, frame length, product stream
//              in, result stream out)
//
// Parameters:
//   PW  product width (signed); AW accumulator width, must be >= PW;
//   CW  frame-length counter width.
//
// Frame flow:
//   IDLE  first product of a frame loads the accumulator and samples frame_len
//   ACC   further products are added with saturation
//   DONE  result held with acc_valid high until acc_ready; no products taken
// The DONE->IDLE handoff cycle is the single bubble per frame.
// -----------------------------------------------------------------------------
module mult_acc_stage #(
    parameter int PW = 16,
    parameter int AW = 24,
    parameter int CW = 8
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    mult_acc_stage_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            sat_q, sat_d;
    logic [CW-1:0]   rem_q, rem_d;        // products still expected after the current one
    logic            acc_valid_q, acc_valid_d;

    // -------------------------------------------------------------------------
    // Product sign extension to accumulator width
    // -------------------------------------------------------------------------
    logic [AW-1:0] prod_ext;

    genvar gi;
    generate
        for (gi = 0; gi < AW; gi++) begin : g_ext
            if (gi < PW) begin : g_lo
                assign prod_ext[gi] = bus.prod_data[gi];
            end else begin : g_hi
                assign prod_ext[gi] = bus.prod_data[PW-1];
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Saturating adder. One guard bit is enough: the sum of two AW-bit signed
    // values always fits in AW+1 bits, and overflow shows up as the top two
    // bits disagreeing. The guard bit then tells which way to clamp.
    // -------------------------------------------------------------------------
    logic [AW:0]   sum_wide;
    logic          sum_ovf;
    logic [AW-1:0] sum_sat;

    always_comb begin
        sum_wide = {acc_q[AW-1], acc_q} + {prod_ext[AW-1], prod_ext};
        sum_ovf  = sum_wide[AW] ^ sum_wide[AW-1];
        sum_sat  = sum_wide[AW-1:0];
        if (sum_ovf) begin
            if (sum_wide[AW]) begin
                sum_sat = {1'b1, {(AW-1){1'b0}}};   // most negative
            end else begin
                sum_sat = {1'b0, {(AW-1){1'b1}}};   // most positive
            end
        end
    end

    // -------------------------------------------------------------------------
    // Handshake decode. prod_ready depends only on state, enable and reset so
    // that neither prod_valid nor acc_ready can form a combinational loop
    // through this stage.
    // -------------------------------------------------------------------------
    logic prod_ready_int;
    logic prod_accept;
    logic res_handoff;

    assign prod_ready_int = sys_rst_n & bus.en & (state_q != S_DONE);
    assign prod_accept    = bus.prod_valid & prod_ready_int;
    assign res_handoff    = acc_valid_q & bus.acc_ready;

    // Remaining count after the first product; a frame_len of 0 counts as 1.
    logic [CW-1:0] first_rem;
    assign first_rem = (bus.frame_len == '0) ? '0 : bus.frame_len - CW'(1);

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        rem_d       = rem_q;
        acc_valid_d = acc_valid_q;

        if (!bus.en) begin
            // Enable low discards any frame in flight, same as reset.
            state_d     = S_IDLE;
            acc_d       = '0;
            sat_d       = 1'b0;
            rem_d       = '0;
            acc_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (prod_accept) begin
                        acc_d = prod_ext;
                        sat_d = 1'b0;
                        rem_d = first_rem;
                        if (first_rem == '0) begin
                            state_d     = S_DONE;
                            acc_valid_d = 1'b1;
                        end else begin
                            state_d = S_ACC;
                        end
                    end
                end

                S_ACC: begin
                    if (prod_accept) begin
                        acc_d = sum_sat;
                        sat_d = sat_q | sum_ovf;
                        rem_d = rem_q - CW'(1);
                        if (rem_q == CW'(1)) begin
                            state_d     = S_DONE;
                            acc_valid_d = 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    // acc_data is intentionally kept after handoff; only the
                    // next frame start overwrites it.
                    if (res_handoff) begin
                        state_d     = S_IDLE;
                        acc_valid_d = 1'b0;
                    end
                end

                default: begin
                    state_d     = S_IDLE;
                    acc_valid_d = 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            rem_q       <= '0;
            acc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            rem_q       <= rem_d;
            acc_valid_q <= acc_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.prod_ready = prod_ready_int;
    assign bus.acc_valid  = acc_valid_q;
    assign bus.acc_data   = acc_q;
    assign bus.acc_sat    = sat_q;

endmodule : mult_acc_stage

// File: tb/tb_mult_acc_stage.sv
// -----------------------------------------------------------------------------
// tb_mult_acc_stage
//
// Two instances share one stimulus stream: a default-width accumulator
// (AW=24) and a narrow one (AW=17) that saturates on 16-bit products.
// Table vectors carry hand-computed results for both widths; hand sequences
// cover reset/enable/backpressure corners; random frames are checked against
// a plain-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_mult_acc_stage;

    logic               sys_clk;
    logic               sys_rst_n;
    logic               en;
    logic [7:0]         frame_len;
    logic               prod_valid;
    logic signed [15:0] prod_data;
    logic               acc_ready;

    int checks = 0;
    int errors = 0;

    mult_acc_stage_if #(.PW(16), .AW(24), .CW(8)) bus ();
    mult_acc_stage_if #(.PW(16), .AW(17), .CW(8)) sbus ();

    assign bus.en          = en;
    assign bus.frame_len   = frame_len;
    assign bus.prod_valid  = prod_valid;
    assign bus.prod_data   = prod_data;
    assign bus.acc_ready   = acc_ready;
    assign sbus.en         = en;
    assign sbus.frame_len  = frame_len;
    assign sbus.prod_valid = prod_valid;
    assign sbus.prod_data  = prod_data;
    assign sbus.acc_ready  = acc_ready;

    mult_acc_stage #(.PW(16), .AW(24), .CW(8)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    mult_acc_stage #(.PW(16), .AW(17), .CW(8)) dut_s (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (sbus)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // Offer one product and return #1 after the edge that accepts it.
    task automatic put_prod(input logic signed [15:0] v);
        int guard;
        guard      = 0;
        prod_valid = 1'b1;
        prod_data  = v;
        while (!bus.prod_ready && guard < 50) begin
            @(posedge sys_clk);
            #1;
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $display("FAIL prod_ready_wait act=0 exp=1");
        end
        @(posedge sys_clk);
        #1;
        prod_valid = 1'b0;
        prod_data  = '0;
    endtask

    // Called #1 after the last accept of a frame. acc_ready must already be
    // low when hold > 0 so the result sits in DONE for hold cycles.
    task automatic finish_frame(input string tag, input int hold,
                                input longint e24, input bit s24,
                                input longint e17, input bit s17);
        chk({tag, "_valid"},  longint'(bus.acc_valid),  1);
        chk({tag, "_svalid"}, longint'(sbus.acc_valid), 1);
        chk({tag, "_bubble"}, longint'(bus.prod_ready), 0);
        for (int k = 0; k < hold; k++) begin
            @(posedge sys_clk);
            #1;
            chk({tag, "_hold_valid"}, longint'(bus.acc_valid), 1);
            chk({tag, "_hold_ready"}, longint'(bus.prod_ready), 0);
            chk({tag, "_hold_data"},  longint'(bus.acc_data), e24);
        end
        chk({tag, "_data24"}, longint'(bus.acc_data),  e24);
        chk({tag, "_sat24"},  longint'(bus.acc_sat),   longint'(s24));
        chk({tag, "_data17"}, longint'(sbus.acc_data), e17);
        chk({tag, "_sat17"},  longint'(sbus.acc_sat),  longint'(s17));
        $display("frame %s: acc24=%0d sat24=%0d acc17=%0d sat17=%0d",
                 tag, bus.acc_data, bus.acc_sat, sbus.acc_data, sbus.acc_sat);
        acc_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        chk({tag, "_handoff"},  longint'(bus.acc_valid),  0);
        chk({tag, "_shandoff"}, longint'(sbus.acc_valid), 0);
        chk({tag, "_ready"},    longint'(bus.prod_ready), 1);
    endtask

    // Reference: first product loads, each later one adds and clamps to
    // the signed aw-bit range; any clamp marks the frame saturated.
    function automatic void model(input longint q[$], input int aw,
                                  output longint res, output bit sat);
        longint mx;
        longint mn;
        longint t;
        mx  = (longint'(1) <<< (aw - 1)) - 1;
        mn  = -(longint'(1) <<< (aw - 1));
        res = q[0];
        sat = 1'b0;
        for (int i = 1; i < q.size(); i++) begin
            t = res + q[i];
            if (t > mx) begin
                res = mx;
                sat = 1'b1;
            end else if (t < mn) begin
                res = mn;
                sat = 1'b1;
            end else begin
                res = t;
            end
        end
    endfunction

    // -------------------------------------------------------------------------
    // Vector table
    // -------------------------------------------------------------------------
    typedef struct {
        int              flen;
        int              n;
        logic [3:0][15:0] p;
        longint          e24;
        bit              s24;
        longint          e17;
        bit              s17;
    } vec_t;

    function automatic vec_t mk(input int flen, input int n,
                                input int p0, input int p1, input int p2, input int p3,
                                input longint e24, input bit s24,
                                input longint e17, input bit s17);
        vec_t v;
        v.flen = flen;
        v.n    = n;
        v.p[0] = 16'(p0);
        v.p[1] = 16'(p1);
        v.p[2] = 16'(p2);
        v.p[3] = 16'(p3);
        v.e24  = e24;
        v.s24  = s24;
        v.e17  = e17;
        v.s17  = s17;
        return v;
    endfunction

    vec_t vt [8];

    initial begin
        logic signed [15:0] v;
        longint q[$];
        longint e24, e17;
        bit     s24, s17;
        int     flen, n, hold;

        vt[0] = mk(3, 3,    300,  -1000,     50,      0,     -650, 0,   -650, 0);
        vt[1] = mk(1, 1,      7,      0,      0,      0,        7, 0,      7, 0);
        vt[2] = mk(0, 1,    -12,      0,      0,      0,      -12, 0,    -12, 0);
        vt[3] = mk(3, 3,  32767,  32767,  32767,      0,    98301, 0,  65535, 1);
        vt[4] = mk(3, 3, -32768, -32768, -32768,      0,   -98304, 0, -65536, 1);
        vt[5] = mk(4, 4,  32767,  32767,  32767, -32768,    65533, 0,  32767, 1);
        vt[6] = mk(2, 2,      5,      9,      0,      0,       14, 0,     14, 0);
        vt[7] = mk(4, 4, -32768, -32768, -32768, -32768,  -131072, 0, -65536, 1);

        sys_rst_n  = 1'b0;
        en         = 1'b1;
        frame_len  = '0;
        prod_valid = 1'b0;
        prod_data  = '0;
        acc_ready  = 1'b1;

        // Reset state, observed while reset is still asserted.
        #2;
        chk("rst_valid", longint'(bus.acc_valid),  0);
        chk("rst_data",  longint'(bus.acc_data),   0);
        chk("rst_sat",   longint'(bus.acc_sat),    0);
        chk("rst_ready", longint'(bus.prod_ready), 0);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        #1;
        chk("rst_rel_ready", longint'(bus.prod_ready), 1);

        // Table vectors, back-to-back, acc_ready held high throughout.
        for (int t = 0; t < 8; t++) begin
            frame_len = 8'(vt[t].flen);
            for (int i = 0; i < vt[t].n; i++) begin
                put_prod($signed(vt[t].p[i]));
            end
            finish_frame($sformatf("vec%0d", t), 0,
                         vt[t].e24, vt[t].s24, vt[t].e17, vt[t].s17);
        end

        // Reset in the middle of a frame.
        frame_len = 8'd4;
        put_prod(16'sd100);
        put_prod(16'sd200);
        sys_rst_n = 1'b0;
        #1;
        chk("midrst_valid", longint'(bus.acc_valid),  0);
        chk("midrst_data",  longint'(bus.acc_data),   0);
        chk("midrst_ready", longint'(bus.prod_ready), 0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        #1;
        frame_len = 8'd1;
        put_prod(16'sd7);
        finish_frame("midrst_next", 0, 7, 0, 7, 0);

        // Input gaps and a 4-cycle result backpressure.
        acc_ready = 1'b0;
        frame_len = 8'd2;
        put_prod(16'sd5);
        repeat (3) begin
            @(posedge sys_clk);
            #1;
        end
        chk("stall_valid", longint'(bus.acc_valid), 0);
        put_prod(16'sd9);
        finish_frame("bp", 4, 14, 0, 14, 0);
        chk("bp_keep_data", longint'(bus.acc_data), 14);

        // frame_len change after the first accept is ignored.
        frame_len = 8'd5;
        put_prod(16'sd1);
        frame_len = 8'd2;
        put_prod(16'sd2);
        put_prod(16'sd3);
        chk("midlen_notdone", longint'(bus.acc_valid), 0);
        put_prod(16'sd4);
        put_prod(16'sd5);
        finish_frame("midlen", 0, 15, 0, 15, 0);

        // Enable dropped in ACC discards the frame.
        frame_len = 8'd4;
        put_prod(16'sd10);
        put_prod(16'sd20);
        en = 1'b0;
        #1;
        chk("en_ready_low", longint'(bus.prod_ready), 0);
        @(posedge sys_clk);
        #1;
        chk("en_data",  longint'(bus.acc_data),  0);
        chk("en_valid", longint'(bus.acc_valid), 0);
        chk("en_sat",   longint'(sbus.acc_sat),  0);
        en = 1'b1;
        #1;
        chk("en_idle_ready", longint'(bus.prod_ready), 1);
        frame_len = 8'd2;
        put_prod(16'sd3);
        put_prod(16'sd4);
        finish_frame("en_next", 0, 7, 0, 7, 0);

        // Longest frame.
        frame_len = 8'd255;
        for (int i = 0; i < 255; i++) begin
            put_prod(16'sd32767);
            if (i == 253) chk("len255_notdone", longint'(bus.acc_valid), 0);
        end
        finish_frame("len255", 0, 8355585, 0, 65535, 1);

        // Random frames against the reference model.
        for (int f = 0; f < 40; f++) begin
            flen      = $urandom_range(0, 6);
            n         = (flen == 0) ? 1 : flen;
            hold      = $urandom_range(0, 3);
            acc_ready = (hold == 0);
            frame_len = 8'(flen);
            q.delete();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0:       v = 16'sh7FFF;
                    1:       v = 16'sh8000;
                    default: v = 16'($urandom);
                endcase
                if (i > 0 && $urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 2)) begin
                        @(posedge sys_clk);
                        #1;
                    end
                end
                put_prod(v);
                q.push_back(longint'(v));
                if (i == 0) frame_len = 8'($urandom_range(0, 255));
            end
            model(q, 24, e24, s24);
            model(q, 17, e17, s17);
            finish_frame($sformatf("rnd%0d", f), hold, e24, s24, e17, s17);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mult_acc_stage
